// File: rtl/fs_pkg.sv
// Purpose : shared types and constants for the bit-serial subtractor slice.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, default operand width and its counter width.
package fs_pkg;

   localparam int FS_WIDTH = 32;
   localparam int FS_CNT_W = $clog2(FS_WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } fs_state_e;

endpackage

// File: rtl/fs1bit.sv
// Purpose : 1-bit full subtractor cell, diff = a - b - bin.
// Latency : combinational.
// Backpressure: none.
// Ports   : a, b, bin (in, 1b) ; diff, bout (out, 1b).
module fs1bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b ^ bin;
   // Borrow when b exceeds a outright, or when a == b and a borrow is pending.
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/fs32bit_serial.sv
// Purpose : bit-serial n-bit subtractor d = a - b - bin, LSB first, one fs1bit cell.
// Latency : done pulses n+1 edges after the accepting edge; one op per n+2 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
// Ports   : clk, rst (sync, active-high), start, a[n], b[n], bin in;
//           busy, done (1-cycle pulse), d[n], bout out (d/bout held until next done).
module fs32bit_serial
   import fs_pkg::*;
#(
   parameter int n = FS_WIDTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   input  logic         bin,
   output logic         busy,
   output logic         done,
   output logic [n-1:0] d,
   output logic         bout
);

   localparam int CW = $clog2(n);

   fs_state_e    state;
   logic [n-1:0] a_sr;
   logic [n-1:0] b_sr;
   logic [n-1:0] res_sr;
   logic         br;
   logic [CW-1:0] cnt;
   logic         diff;
   logic         br_nxt;

   fs1bit u_cell (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (br),
      .diff (diff),
      .bout (br_nxt)
   );

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         br     <= 1'b0;
         cnt    <= '0;
         done   <= 1'b0;
         d      <= '0;
         bout   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  br    <= bin;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               // Result fills from the top so bit 0 lands in d[0] after n shifts.
               res_sr <= {diff, res_sr[n-1:1]};
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               br     <= br_nxt;
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(n - 1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b1;
               d     <= res_sr;
               bout  <= br;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fs32bit_serial.sv
// Purpose : self-checking bench for fs32bit_serial with a cycle model and result scoreboard.
// Latency : model predicts busy/done per cycle; results popped when done is seen.
// Backpressure: exercises start held high while busy and a mid-operation reset.
module tb_fs32bit_serial;

   localparam int N = 32;

   logic         clk;
   logic         rst;
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [N-1:0] d;
   logic         bout;

   int n_chk  = 0;
   int n_fail = 0;

   fs32bit_serial #(.n(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .d     (d),
      .bout  (bout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: {borrow, diff} of an (N+1)-bit subtraction.
   function automatic logic [N:0] sub_ref(input logic [N-1:0] x, input logic [N-1:0] y,
                                          input logic bi);
      return {1'b0, x} - {1'b0, y} - {{N{1'b0}}, bi};
   endfunction

   function automatic logic [N-1:0] add_ref(input logic [N-1:0] x, input logic [N-1:0] y,
                                            input logic ci);
      return x + y + {{(N-1){1'b0}}, ci};
   endfunction

   // Cycle model + scoreboard. Inputs change at posedge+1, so values seen at a
   // negedge are the values the following posedge samples.
   logic         s_rst   = 1'b1;
   logic         s_start = 1'b0;
   logic [N-1:0] s_a     = '0;
   logic [N-1:0] s_b     = '0;
   logic         s_bin   = 1'b0;
   int           mcnt    = 0;
   logic         mdone   = 1'b0;
   int           cyc     = 0;
   logic [N:0]   sb_q[$];
   int           acc_q[$];
   logic [N:0]   hold    = '0;
   logic [N:0]   e;
   int           lat;

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (s_rst) begin
            mcnt  = 0;
            mdone = 1'b0;
            sb_q.delete();
            acc_q.delete();
            hold  = '0;
         end else begin
            mdone = (mcnt == 1);
            if (mcnt > 0) begin
               mcnt--;
            end else if (s_start) begin
               mcnt = N + 1;
               sb_q.push_back(sub_ref(s_a, s_b, s_bin));
               acc_q.push_back(cyc);
            end
         end
         check("busy", 64'(busy), 64'(mcnt > 0));
         check("done", 64'(done), 64'(mdone));
         if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
               check("done_without_op", 64'(sb_q.size()), 64'(1));
            end else begin
               e    = sb_q.pop_front();
               lat  = cyc - acc_q.pop_front();
               check("latency", 64'(lat), 64'(N + 1));
               hold = e;
            end
         end
         check("d", 64'(d), 64'(hold[N-1:0]));
         check("bout", 64'(bout), 64'(hold[N]));
         s_rst   = rst;
         s_start = start;
         s_a     = a;
         s_b     = b;
         s_bin   = bin;
      end
   end

   task automatic wait_done(input string tag, input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check({tag, "_timeout"}, 64'(0), 64'(1));
   endtask

   task automatic op(input string tag, input logic [N-1:0] xa, input logic [N-1:0] xb,
                     input logic xbin, input logic [N-1:0] exp_d, input logic exp_bo);
      @(posedge clk); #1;
      a     = xa;
      b     = xb;
      bin   = xbin;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a     = ~xa;
      wait_done(tag, 3 * N);
      check({tag, "_d"}, 64'(d), 64'(exp_d));
      check({tag, "_bout"}, 64'(bout), 64'(exp_bo));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   logic [N-1:0] s;
   logic [N:0]   r;
   int           nd;

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_d", 64'(d), 64'(0));

      op("sub_10_3", 10, 3, 1'b0, 7, 1'b0);
      op("sub_0_1", 0, 1, 1'b0, 32'hFFFF_FFFF, 1'b1);
      op("sub_msb_bin", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1);

      // start held high: second acceptance lands on the IDLE cycle after DONE.
      @(posedge clk); #1;
      a     = 5;
      b     = 2;
      bin   = 1'b0;
      start = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      a = 100;
      wait_done("held_1", 3 * N);
      check("held_1_d", 64'(d), 64'(3));
      @(posedge clk); #1;
      start = 1'b0;
      check("held_2_busy", 64'(busy), 64'(1));
      wait_done("held_2", 3 * N);
      check("held_2_d", 64'(d), 64'(98));

      // Reset in the middle of an operation.
      @(posedge clk); #1;
      a     = 1000;
      b     = 1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_done", 64'(done), 64'(0));
      check("midrst_d", 64'(d), 64'(0));
      check("midrst_bout", 64'(bout), 64'(0));
      nd = 0;
      for (int i = 0; i < 2 * N; i++) begin
         @(negedge clk);
         if (done === 1'b1) nd++;
      end
      check("midrst_no_done", 64'(nd), 64'(0));
      op("sub_20_20", 20, 20, 1'b0, 0, 1'b0);

      // Recover an adder operand.
      s = add_ref(30000, 10000, 1'b0);
      op("roundtrip", s, 10000, 1'b0, 30000, 1'b0);

      for (int k = 0; k <= 50; k++) begin
         r = sub_ref(N'(k * 10000), N'(k * 7), 1'b0);
         op("sweep", N'(k * 10000), N'(k * 7), 1'b0, r[N-1:0], 1'b0);
      end

      for (int i = 0; i < 8; i++) begin
         logic [N-1:0] ra;
         logic [N-1:0] rb;
         logic         rbi;
         ra  = $urandom;
         rb  = $urandom;
         rbi = 1'($urandom_range(0, 1));
         r   = sub_ref(ra, rb, rbi);
         op("rand", ra, rb, rbi, r[N-1:0], r[N]);
      end

      repeat (4) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fs32bit_serial.md
Name: fs32bit_serial

Overview:
Bit-serial 32-bit full subtractor, the inverse-operation companion to the team's 32-bit adder.
- Computes d = a - b - bin one bit per clock, LSB first, with a start/busy/done handshake.
- Serves as the subtract/check path beside the adder: a result from the adder can be fed back through this block to recover an operand.
- Trades latency (n+1 cycles) for a single 1-bit subtractor cell.

Parameters:
- n, 32, operand/result width in bits (n >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only in IDLE
- a  input  n  minuend; latched when start is accepted
- b  input  n  subtrahend; latched when start is accepted
- bin  input  1  borrow-in; latched when start is accepted
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle pulse; d/bout valid
- d  output  n  difference a - b - bin, modulo 2^n
- bout  output  1  borrow-out; 1 iff a < b + bin, unsigned

Behaviour:
- Reset: rst high at a rising edge forces the following, overriding all other activity including mid-operation:
  - state=IDLE, busy=0, done=0, d=0, bout=0;
  - internal shift registers, borrow and counter cleared.
- States and transitions:
  - IDLE: start=1 -> SHIFT. On that edge, latch a, b and bin into the borrow register; counter=0; start=0 -> stay.
  - SHIFT: each edge processes the LSB of the a/b shift registers:
    - diff = a0 ^ b0 ^ br;
    - br_next = (~a0 & b0) | (~(a0 ^ b0) & br);
    - diff is shifted into the MSB of the result register; a and b shift right; counter increments;
    - on the edge where counter == n-1 -> DONE.
  - DONE: done=1 for exactly one cycle; d = result register; bout = final borrow; -> IDLE unconditionally.
- Latency: start accepted at edge k -> done high during the cycle after edge k+n+1.
  - For n=32, done rises 33 edges after the accepting edge.
- Output hold: d and bout hold their value from DONE until the next DONE or reset. They do not change during a subsequent SHIFT.
- start while busy (SHIFT or DONE): ignored, with no effect on the operation in flight.
  - The earliest next acceptance is the IDLE cycle after DONE, giving a throughput of 1 op per n+2 cycles.
- a, b and bin may change freely after acceptance; only the latched values are used.
- Arithmetic is unsigned, wrapping modulo 2^n. bout is the true borrow-out of the n-bit chain.
- busy = (state != IDLE). done is registered; no combinational path from start to any output.

Decomposition:
- Shared package fs_pkg:
  - state encoding IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - default width constant FS_WIDTH=32;
  - counter width = clog2(FS_WIDTH).
- Sub-module fs1bit: combinational 1-bit full subtractor (a, b, bin -> diff, bout). Instantiated once in the datapath.
- FSM, counter and shift registers live in fs32bit_serial.

Test Plan:
- a=10, b=3, bin=0, start pulse -> done exactly 33 edges after acceptance; d=7, bout=0; busy high for 33 cycles (32 SHIFT + 1 DONE).
- a=0, b=1, bin=0 -> d=32'hFFFFFFFF, bout=1. Then a=32'h80000000, b=32'h80000000, bin=1 -> d=32'hFFFFFFFF, bout=1.
- start held high continuously with a=5, b=2:
  - first op gives d=3;
  - start pulses during SHIFT and DONE are ignored (no extra done);
  - second acceptance occurs in the IDLE cycle after DONE;
  - change a to 100 mid-SHIFT -> d still 3.
- rst asserted at SHIFT cycle 10 of op a=1000, b=1 -> next cycle busy=0, done=0, d=0, bout=0; no done pulse follows. A new op a=20, b=20 gives d=0, bout=0.
- Round-trip with the adder: drive a=30000, b=10000 through the 32-bit adder (cin=0) to get s=40000. Feed a=s, b=10000, bin=0 here -> d=30000, bout=0.
- Sweep a=k*10000, b=k*7, k=0..50 -> d matches the reference model (a-b) mod 2^32, and bout=0 for all k.
